// File: rtl/sprite_pkg.sv
// Shared sprite constants and fetch sequencer state encoding.
package sprite_pkg;

  localparam int unsigned SPR_W_DEFAULT   = 20;
  localparam int unsigned SPR_H_DEFAULT   = 22;
  localparam int unsigned ADDR_W_DEFAULT  = 9;
  localparam int unsigned COLOR_W_DEFAULT = 12;
  localparam logic [11:0] KEY_COLOR_DEFAULT = 12'h808;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    READY = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/sprite_line_buf.sv
// One-row sprite color buffer: single registered write port, combinational read port.
module sprite_line_buf #(
  parameter int unsigned DEPTH   = 20,
  parameter int unsigned COLOR_W = 12,
  parameter int unsigned AW      = 5
) (
  input  logic               clk,
  input  logic               we,
  input  logic [AW-1:0]      waddr,
  input  logic [COLOR_W-1:0] wdata,
  input  logic [AW-1:0]      raddr,
  output logic [COLOR_W-1:0] rdata
);

  logic [COLOR_W-1:0] mem [DEPTH];

  // Capture one fetched color per write strobe; contents are not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sprite_line_fetcher.sv
// Per-scanline sprite row fetcher: copies one ROM row into a line buffer
// during hblank, then serves color/opacity for the current active column.
module sprite_line_fetcher
  import sprite_pkg::*;
#(
  parameter int unsigned SPR_W     = SPR_W_DEFAULT,
  parameter int unsigned SPR_H     = SPR_H_DEFAULT,
  parameter int unsigned ADDR_W    = ADDR_W_DEFAULT,
  parameter int unsigned COLOR_W   = COLOR_W_DEFAULT,
  parameter logic [COLOR_W-1:0] KEY_COLOR = COLOR_W'(KEY_COLOR_DEFAULT)
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               line_start,
  input  logic [9:0]         next_y,
  input  logic [9:0]         sprite_x,
  input  logic [9:0]         sprite_y,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [COLOR_W-1:0] rom_color,
  input  logic [9:0]         draw_x,
  output logic [COLOR_W-1:0] pixel_color,
  output logic               pixel_on,
  output logic               fetch_busy
);

  localparam int unsigned COL_W = $clog2(SPR_W);

  fetch_state_t       state;
  logic [COL_W-1:0]   col;
  logic               line_hit;
  logic [9:0]         sx_q;

  logic [9:0]         row_c;
  logic               hit_c;
  logic [ADDR_W-1:0]  row_a_c;
  logic [ADDR_W-1:0]  base_c;
  logic [9:0]         dx_c;
  logic               in_c;
  logic [COL_W-1:0]   raddr_c;
  logic [COLOR_W-1:0] rdata_c;
  logic               we_c;

  // Row of the sprite hit by the upcoming line; wrap makes above-top rows miss.
  assign row_c   = next_y - sprite_y;
  assign hit_c   = row_c < 10'(SPR_H);
  assign row_a_c = ADDR_W'(row_c);
  assign base_c  = (row_a_c << 4) + (row_a_c << 2);

  // Column inside the sprite; wrap makes left-of-sprite columns fall outside.
  assign dx_c    = draw_x - sx_q;
  assign in_c    = dx_c < 10'(SPR_W);
  assign raddr_c = in_c ? COL_W'(dx_c) : '0;

  // A restarting line_start suppresses the stale write of the aborted fetch.
  assign we_c = (state == FETCH) && !line_start;

  sprite_line_buf #(
    .DEPTH   (SPR_W),
    .COLOR_W (COLOR_W),
    .AW      (COL_W)
  ) u_buf (
    .clk   (Clk),
    .we    (we_c),
    .waddr (col),
    .wdata (rom_color),
    .raddr (raddr_c),
    .rdata (rdata_c)
  );

  // Fetch sequencer: line_start (re)starts from any state, FETCH walks one row.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= IDLE;
      rom_addr   <= '0;
      col        <= '0;
      line_hit   <= 1'b0;
      fetch_busy <= 1'b0;
      sx_q       <= '0;
    end else if (line_start) begin
      sx_q <= sprite_x;
      col  <= '0;
      if (hit_c) begin
        line_hit   <= 1'b1;
        rom_addr   <= base_c;
        state      <= FETCH;
        fetch_busy <= 1'b1;
      end else begin
        line_hit   <= 1'b0;
        state      <= READY;
        fetch_busy <= 1'b0;
      end
    end else begin
      case (state)
        FETCH: begin
          if (col == COL_W'(SPR_W - 1)) begin
            state      <= READY;
            fetch_busy <= 1'b0;
          end else begin
            col      <= col + COL_W'(1);
            rom_addr <= rom_addr + ADDR_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Pixel path: one-cycle registered lookup of the buffered row.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      pixel_on    <= 1'b0;
      pixel_color <= KEY_COLOR;
    end else begin
      pixel_on    <= (state == READY) && line_hit && in_c && (rdata_c != KEY_COLOR);
      pixel_color <= in_c ? rdata_c : KEY_COLOR;
    end
  end

endmodule

// File: tb/tb_sprite_line_fetcher.sv
// Directed self-checking bench for sprite_line_fetcher.
module tb_sprite_line_fetcher;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        line_start;
  logic [9:0]  next_y;
  logic [9:0]  sprite_x;
  logic [9:0]  sprite_y;
  logic [8:0]  rom_addr;
  logic [11:0] rom_color;
  logic [9:0]  draw_x;
  logic [11:0] pixel_color;
  logic        pixel_on;
  logic        fetch_busy;

  int checks   = 0;
  int failures = 0;

  sprite_line_fetcher dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .line_start  (line_start),
    .next_y      (next_y),
    .sprite_x    (sprite_x),
    .sprite_y    (sprite_y),
    .rom_addr    (rom_addr),
    .rom_color   (rom_color),
    .draw_x      (draw_x),
    .pixel_color (pixel_color),
    .pixel_on    (pixel_on),
    .fetch_busy  (fetch_busy)
  );

  always #5 Clk = ~Clk;

  // ROM model: row 0 has four key-colored columns then 12'hF30; other rows
  // hold the address XOR 12'h5A5 (never equal to the key in range 20..439).
  function automatic logic [11:0] rom_model(input logic [8:0] a);
    if (a < 9'd4)       return 12'h808;
    else if (a < 9'd20) return 12'hF30;
    else                return 12'(a) ^ 12'h5A5;
  endfunction

  always_comb rom_color = rom_model(rom_addr);

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulse line_start; afterwards outputs show cycle T+1.
  task automatic start_line(input logic [9:0] ny, input logic [9:0] sx, input logic [9:0] sy);
    next_y     = ny;
    sprite_x   = sx;
    sprite_y   = sy;
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
  endtask

  // Called right after start_line: checks the 20-address walk and READY at T+21.
  task automatic check_walk(input string tag, input int base);
    for (int i = 0; i < 21; i++) begin
      check({tag, "_addr"}, 32'(rom_addr), 32'(base + ((i < 19) ? i : 19)));
      check({tag, "_busy"}, 32'(fetch_busy), 32'(i < 20));
      if (i < 20) tick();
    end
  endtask

  initial begin
    Reset      = 1'b1;
    line_start = 1'b0;
    next_y     = '0;
    sprite_x   = '0;
    sprite_y   = '0;
    draw_x     = '0;
    tick();
    tick();
    check("rst_addr",  32'(rom_addr),    32'd0);
    check("rst_busy",  32'(fetch_busy),  32'd0);
    check("rst_on",    32'(pixel_on),    32'd0);
    check("rst_color", 32'(pixel_color), 32'h808);
    Reset = 1'b0;
    tick();

    // Reset asserted while the fetch is at column 7.
    start_line(10'd105, 10'd0, 10'd100);
    for (int i = 0; i < 7; i++) tick();
    check("midfetch_addr", 32'(rom_addr), 32'd107);
    check("midfetch_busy", 32'(fetch_busy), 32'd1);
    Reset = 1'b1;
    tick();
    check("rstmid_addr",  32'(rom_addr),    32'd0);
    check("rstmid_busy",  32'(fetch_busy),  32'd0);
    check("rstmid_on",    32'(pixel_on),    32'd0);
    check("rstmid_color", 32'(pixel_color), 32'h808);
    Reset = 1'b0;
    tick();

    // Row 5 hit: addresses 100..119, busy for exactly 20 cycles.
    start_line(10'd105, 10'd0, 10'd100);
    check_walk("row5", 100);

    // Left clip: sprite_x wraps to 1020, draw_x 0..15 shows buf[4..19].
    start_line(10'd105, 10'd1020, 10'd100);
    for (int i = 0; i < 20; i++) tick();
    for (int i = 0; i < 17; i++) begin
      draw_x = 10'(i);
      tick();
      check("clip_on",    32'(pixel_on),    32'(i < 16));
      check("clip_color", 32'(pixel_color),
            (i < 16) ? 32'((12'(104 + i)) ^ 12'h5A5) : 32'h808);
    end

    // Misses below and above the sprite: READY at T+1, never opaque.
    start_line(10'd122, 10'd0, 10'd100);
    check("miss_lo_busy", 32'(fetch_busy), 32'd0);
    check("miss_lo_addr", 32'(rom_addr), 32'd119);
    for (int i = 0; i < 24; i += 3) begin
      draw_x = 10'(i);
      tick();
      check("miss_lo_on", 32'(pixel_on), 32'd0);
    end
    start_line(10'd99, 10'd0, 10'd100);
    check("miss_hi_busy", 32'(fetch_busy), 32'd0);
    for (int i = 0; i < 24; i += 3) begin
      draw_x = 10'(i);
      tick();
      check("miss_hi_on", 32'(pixel_on), 32'd0);
    end

    // Transparency on row 0 at sprite_x=50.
    start_line(10'd100, 10'd50, 10'd100);
    check_walk("row0", 0);
    for (int x = 49; x <= 70; x++) begin
      draw_x = 10'(x);
      tick();
      check("trans_on", 32'(pixel_on), 32'((x >= 54) && (x <= 69)));
      check("trans_color", 32'(pixel_color), ((x >= 54) && (x <= 69)) ? 32'hF30 : 32'h808);
    end

    // Last row: addresses 420..439.
    start_line(10'd121, 10'd0, 10'd100);
    check_walk("row21", 420);

    // Restart at T+10: first fetch row 3 (base 60), then row 10 (base 200).
    start_line(10'd103, 10'd0, 10'd100);
    for (int i = 0; i < 9; i++) tick();
    check("restart_pre_addr", 32'(rom_addr), 32'd69);
    start_line(10'd110, 10'd0, 10'd100);
    check_walk("restart", 200);
    for (int i = 0; i < 21; i++) begin
      draw_x = 10'(i);
      tick();
      check("restart_on", 32'(pixel_on), 32'(i < 20));
      check("restart_color", 32'(pixel_color),
            (i < 20) ? 32'((12'(200 + i)) ^ 12'h5A5) : 32'h808);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
